// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM state encoding, instruction width,
// default reset PC and the instruction word used to fill pipeline bubbles.
package cpu_defs;

  localparam int INSTR_W = 32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // ARM "mov r0, r0": harmless if a bubble's word is ever decoded.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/adder.sv
// Plain modulo-2^WIDTH adder.
// Ports: a, b - operands; sum - a + b (carry out discarded).
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory with a
// ready handshake and fills the IF/ID pipeline register. Handles stall
// (through a one-entry skid register), flush and branch redirect, including
// a redirect arriving while a request is still unanswered.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   stall_i, flush_i               - hold IF/ID / squash next IF/ID entry
//   branch_taken_i, branch_target_i- redirect fetch
//   imem_req_o, imem_addr_o        - memory request (decoded from state/pc)
//   imem_ready_i, imem_rdata_i     - memory accept with same-cycle data
//   if_valid_o, if_pc_o, if_pc_plus4_o, if_instr_o - IF/ID register
module fetch_stage
  import cpu_defs::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               branch_taken_i,
  input  logic [WIDTH-1:0]   branch_target_i,
  output logic               imem_req_o,
  output logic [WIDTH-1:0]   imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [WIDTH-1:0]   if_pc_o,
  output logic [WIDTH-1:0]   if_pc_plus4_o,
  output logic [INSTR_W-1:0] if_instr_o
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  fetch_state_e       state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   pc_plus4;
  logic               pending_q, pending_d;
  logic [WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic [WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               if_valid_d;
  logic [WIDTH-1:0]   if_pc_d, if_pc_plus4_d;
  logic [INSTR_W-1:0] if_instr_d;

  // One incrementer serves both the PC update and the IF/ID PC+4 field.
  adder #(.WIDTH(WIDTH)) u_pc_inc (
    .a   (pc_q),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    redirect_pc_d = redirect_pc_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_valid_d    = if_valid_o;
    if_pc_d       = if_pc_o;
    if_pc_plus4_d = if_pc_plus4_o;
    if_instr_d    = if_instr_o;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (!stall_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end
      S_FETCH: begin
        if (!imem_ready_i || pending_q) begin
          // Waiting, or the returning word belongs to a redirected-away path.
          if (imem_ready_i) begin
            pc_d      = redirect_pc_q;
            pending_d = 1'b0;
          end
          if (!stall_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end else if (stall_i) begin
          skid_pc_d    = pc_q;
          skid_instr_d = imem_rdata_i;
          pc_d         = pc_plus4;
          state_d      = S_HOLD;
        end else begin
          if_valid_d    = 1'b1;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_plus4;
          if_instr_d    = imem_rdata_i;
          pc_d          = pc_plus4;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          if_valid_d    = 1'b1;
          if_pc_d       = skid_pc_q;
          // pc already advanced past the skid word, so it is skid_pc + 4.
          if_pc_plus4_d = pc_q;
          if_instr_d    = skid_instr_q;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end

    if (branch_taken_i) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      if (state_q == S_FETCH && !imem_ready_i) begin
        // Address must stay stable until accepted; redirect after ready.
        pending_d     = 1'b1;
        redirect_pc_d = branch_target_i;
        pc_d          = pc_q;
      end else begin
        pending_d = 1'b0;
        pc_d      = branch_target_i;
        state_d   = S_FETCH;
      end
    end
  end

  // NOTE: the skid and redirect registers are reset with everything else;
  // they are a few flops, not a RAM, and a known value costs nothing here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      redirect_pc_q <= RESET_PC;
      skid_pc_q     <= '0;
      skid_instr_q  <= '0;
      if_valid_o    <= 1'b0;
      if_pc_o       <= '0;
      if_pc_plus4_o <= '0;
      if_instr_o    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      redirect_pc_q <= redirect_pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_valid_o    <= if_valid_d;
      if_pc_o       <= if_pc_d;
      if_pc_plus4_o <= if_pc_plus4_d;
      if_instr_o    <= if_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, branch_taken_i, imem_ready_i;
  logic [31:0] branch_target_i, imem_addr_o, imem_rdata_i;
  logic        imem_req_o, if_valid_o;
  logic [31:0] if_pc_o, if_pc_plus4_o, if_instr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_pc_plus4_o   (if_pc_plus4_o),
    .if_instr_o      (if_instr_o)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, expressed as: is a reset-idle cycle pending, the next
  // address to fetch, words parked by a stall, a redirect awaiting the
  // outstanding word, and which PC (if any) sits in IF/ID.
  bit          m_idle;
  logic [31:0] m_pc;
  logic [31:0] m_skid[$];
  logic [31:0] m_pend[$];
  bit          m_valid;
  logic [31:0] m_ifpc;

  // DUT outputs sampled in the most recent step, for literal checks.
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_pc4;

  task automatic model_reset();
    m_idle  = 1'b1;
    m_pc    = 32'h0;
    m_skid.delete();
    m_pend.delete();
    m_valid = 1'b0;
    m_ifpc  = 32'h0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic step(input bit st, input bit fl, input bit br,
                      input logic [31:0] tgt, input bit rdy);
    bit          fetching, n_idle, n_valid;
    logic [31:0] n_pc, n_ifpc;
    logic [31:0] n_skid[$];
    logic [31:0] n_pend[$];
    stall_i         = st;
    flush_i         = fl;
    branch_taken_i  = br;
    branch_target_i = tgt;
    imem_ready_i    = rdy;
    @(negedge clk);
    fetching = !m_idle && (m_skid.size() == 0);
    obs_req = imem_req_o; obs_valid = if_valid_o; obs_addr = imem_addr_o;
    obs_pc  = if_pc_o;    obs_pc4   = if_pc_plus4_o;
    check("req", {31'b0, imem_req_o}, {31'b0, fetching});
    check("addr", imem_addr_o, m_pc);
    check("valid", {31'b0, if_valid_o}, {31'b0, m_valid});
    if (m_valid) begin
      check("if_pc", if_pc_o, m_ifpc);
      check("if_pc4", if_pc_plus4_o, m_ifpc + 32'd4);
      check("if_instr", if_instr_o, mem_word(m_ifpc));
    end

    n_idle = m_idle; n_pc = m_pc; n_valid = m_valid; n_ifpc = m_ifpc;
    n_skid = m_skid; n_pend = m_pend;
    if (m_idle) begin
      n_idle = 1'b0;
      if (!st) n_valid = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        n_valid = 1'b1; n_ifpc = m_skid[0]; n_skid.delete();
      end
    end else if (!rdy) begin
      if (!st) n_valid = 1'b0;
    end else if (m_pend.size() != 0) begin
      n_pc = m_pend[0]; n_pend.delete();
      if (!st) n_valid = 1'b0;
    end else if (st) begin
      n_skid.push_back(m_pc); n_pc = m_pc + 32'd4;
    end else begin
      n_valid = 1'b1; n_ifpc = m_pc; n_pc = m_pc + 32'd4;
    end
    if (fl) n_valid = 1'b0;
    if (br) begin
      n_valid = 1'b0;
      n_skid.delete();
      n_pend.delete();
      if (fetching && !rdy) n_pend.push_back(tgt);
      else begin
        n_pc = tgt; n_idle = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    m_idle = n_idle; m_pc = n_pc; m_valid = n_valid; m_ifpc = n_ifpc;
    m_skid = n_skid; m_pend = n_pend;
  endtask

  task automatic run(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 32'h0; imem_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    do_reset();
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", {31'b0, if_valid_o}, 32'd0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_pc4", if_pc_plus4_o, 32'h0);
    check("rst_instr", if_instr_o, 32'h0);

    // Zero-wait: idle cycle, then 0,4,8,12 back to back.
    run(1'b1); check("first_idle", {31'b0, obs_req}, 32'd0);
    run(1'b1); check("first_addr", obs_addr, 32'h0);
    check("first_nvalid", {31'b0, obs_valid}, 32'd0);
    run(1'b1); check("zw_addr4", obs_addr, 32'h4); check("zw_pc0", obs_pc, 32'h0);
    check("zw_v0", {31'b0, obs_valid}, 32'd1);
    run(1'b1); check("zw_addr8", obs_addr, 32'h8); check("zw_pc4", obs_pc, 32'h4);
    run(1'b1); check("zw_addr12", obs_addr, 32'hC); check("zw_pc8", obs_pc, 32'h8);

    // Wait states at 0x10.
    run(1'b0); check("ws_addr_a", obs_addr, 32'h10);
    run(1'b0); check("ws_addr_b", obs_addr, 32'h10);
    check("ws_bubble_b", {31'b0, obs_valid}, 32'd0);
    run(1'b0); check("ws_addr_c", obs_addr, 32'h10);
    check("ws_bubble_c", {31'b0, obs_valid}, 32'd0);
    run(1'b1); check("ws_addr_d", obs_addr, 32'h10);
    run(1'b1); check("ws_pc10", obs_pc, 32'h10);
    check("ws_v10", {31'b0, obs_valid}, 32'd1);

    // Stall while 0x20 returns.
    run(1'b1); run(1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1); check("st_addr20", obs_addr, 32'h20);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("st_req0", {31'b0, obs_req}, 32'd0); check("st_hold1c", obs_pc, 32'h1C);
    run(1'b1); check("st_req0b", {31'b0, obs_req}, 32'd0);
    check("st_hold1c_b", obs_pc, 32'h1C);
    run(1'b1); check("st_pc20", obs_pc, 32'h20); check("st_resume24", obs_addr, 32'h24);
    run(1'b1); check("st_pc24", obs_pc, 32'h24);

    // Redirect while 0x40 is outstanding.
    n = 0;
    while (m_pc != 32'h40 && n < 30) begin run(1'b1); n++; end
    check("reach_0x40", imem_addr_o, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0); check("ro_addr_a", obs_addr, 32'h40);
    run(1'b0); check("ro_addr_b", obs_addr, 32'h40);
    check("ro_bubble_b", {31'b0, obs_valid}, 32'd0);
    run(1'b1); check("ro_addr_c", obs_addr, 32'h40);
    run(1'b1); check("ro_addr_tgt", obs_addr, 32'h100);
    check("ro_dropped", {31'b0, obs_valid}, 32'd0);
    run(1'b1); check("ro_pc100", obs_pc, 32'h100);
    check("ro_v100", {31'b0, obs_valid}, 32'd1);

    // Branch + flush + stall together, then PC wrap.
    step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    run(1'b1); check("sim_bubble", {31'b0, obs_valid}, 32'd0);
    check("sim_addr", obs_addr, 32'h200);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(1'b1); check("wrap_addr_fc", obs_addr, 32'hFFFF_FFFC);
    run(1'b1); check("wrap_addr0", obs_addr, 32'h0);
    check("wrap_pc", obs_pc, 32'hFFFF_FFFC); check("wrap_pc4", obs_pc4, 32'h0);

    // Asynchronous reset in the middle of a cycle.
    run(1'b1);
    check("ar_pre_req", {31'b0, imem_req_o}, 32'd1);
    check("ar_pre_valid", {31'b0, if_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req", {31'b0, imem_req_o}, 32'd0);
    check("ar_valid", {31'b0, if_valid_o}, 32'd0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                         : {22'h0, $urandom_range(0, 255), 2'b00};
      step($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
           $urandom_range(0, 99) < 8, tgt, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
